// File: rtl/dmem_bank_arbiter.sv
// Two-requester round-robin front end for a single data-memory bank.
// Each access is granted in IDLE, then spends one SETUP and one ACCESS cycle on the bank.
module dmem_bank_arbiter #(
    parameter int unsigned DMEM_ADDR = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [DMEM_ADDR-1:0] req0_addr_i,
    input  logic                 req0_write_i,
    input  logic [31:0]          req0_wdata_i,
    input  logic [2:0]           req0_funct_i,
    output logic                 rsp0_valid_o,
    output logic [31:0]          rsp0_rdata_o,
    output logic                 rsp0_err_o,

    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [DMEM_ADDR-1:0] req1_addr_i,
    input  logic                 req1_write_i,
    input  logic [31:0]          req1_wdata_i,
    input  logic [2:0]           req1_funct_i,
    output logic                 rsp1_valid_o,
    output logic [31:0]          rsp1_rdata_o,
    output logic                 rsp1_err_o,

    output logic [DMEM_ADDR-1:0] paddr_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [31:0]          pwdata_o,
    output logic [2:0]           pfunct_code_o,
    input  logic [31:0]          prdata_i
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e               state_q, state_d;
    logic                 prio_q;      // requester that wins a tie
    logic                 owner_q;
    logic                 grant_any;
    logic                 grant_id;
    logic                 handshake;
    logic                 illegal;
    logic [DMEM_ADDR-1:0] paddr_q;
    logic                 pwrite_q;
    logic [31:0]          pwdata_q;
    logic [2:0]           pfunct_q;
    logic [1:0]           rsp_valid_q;
    logic [1:0]           rsp_err_q;
    logic [1:0][31:0]     rsp_rdata_q;

    always_comb begin
        grant_any = req0_valid_i | req1_valid_i;
        grant_id  = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = prio_q;
        end
        // Gated by reset so ready stays low while rst_ni is asserted.
        handshake    = rst_ni && (state_q == StIdle) && grant_any;
        req0_ready_o = handshake && !grant_id;
        req1_ready_o = handshake && grant_id;
    end

    assign illegal = (pfunct_q[1:0] == 2'b11) || (pfunct_q == 3'd6);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (handshake) state_d = StSetup;
            StSetup:  state_d = illegal ? StIdle : StAccess;
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pfunct_q    <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            if (handshake) begin
                owner_q  <= grant_id;
                prio_q   <= ~grant_id;
                paddr_q  <= grant_id ? req1_addr_i  : req0_addr_i;
                pwrite_q <= grant_id ? req1_write_i : req0_write_i;
                pwdata_q <= grant_id ? req1_wdata_i : req0_wdata_i;
                pfunct_q <= grant_id ? req1_funct_i : req0_funct_i;
            end
            if (state_q == StSetup && illegal) begin
                rsp_valid_q[owner_q] <= 1'b1;
                rsp_err_q[owner_q]   <= 1'b1;
                rsp_rdata_q[owner_q] <= '0;
            end
            // prdata_i is only looked at here, so a floating bus never propagates.
            if (state_q == StAccess) begin
                rsp_valid_q[owner_q] <= 1'b1;
                rsp_rdata_q[owner_q] <= pwrite_q ? 32'h0 : prdata_i;
            end
        end
    end

    assign penable_o     = (state_q == StAccess);
    assign paddr_o       = paddr_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pfunct_code_o = pfunct_q;

    assign rsp0_valid_o  = rsp_valid_q[0];
    assign rsp0_err_o    = rsp_err_q[0];
    assign rsp0_rdata_o  = rsp_rdata_q[0];
    assign rsp1_valid_o  = rsp_valid_q[1];
    assign rsp1_err_o    = rsp_err_q[1];
    assign rsp1_rdata_o  = rsp_rdata_q[1];

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Bench for dmem_bank_arbiter: behavioural bank model plus an in-order response scoreboard.
module tb_dmem_bank_arbiter;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic          req0_write = 1'b0, req1_write = 1'b0;
    logic [31:0]   req0_wdata = '0, req1_wdata = '0;
    logic [2:0]    req0_funct = '0, req1_funct = '0;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0]   rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] paddr;
    logic          penable, pwrite;
    logic [31:0]   pwdata, prdata;
    logic [2:0]    pfunct;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit xz_sel = 1'b0;

    typedef struct {
        bit          id;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    dmem_bank_arbiter #(.DMEM_ADDR(AW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_addr_i(req0_addr),
        .req0_write_i(req0_write), .req0_wdata_i(req0_wdata), .req0_funct_i(req0_funct),
        .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_addr_i(req1_addr),
        .req1_write_i(req1_write), .req1_wdata_i(req1_wdata), .req1_funct_i(req1_funct),
        .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
        .paddr_o(paddr), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
        .pfunct_code_o(pfunct), .prdata_i(prdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) xz_sel <= ~xz_sel;

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] fn);
        case (fn)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'h0, w[7:0]};
            3'd5:    return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] fn);
        case (fn[1:0])
            2'd0:    return {old[31:8], wd[7:0]};
            2'd1:    return {old[31:16], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    // Bank: commits stores on the edge ending ACCESS, floats its read bus otherwise.
    always @(posedge clk) if (penable && pwrite) mem[paddr] <= merge(mem[paddr], pwdata, pfunct);
    always_comb begin
        prdata = {32{1'bz}};
        if (penable)     prdata = ext(mem[paddr], pfunct);
        else if (xz_sel) prdata = {32{1'bx}};
    end

    // Scoreboard: responses must arrive in grant order at the predicted cycle.
    exp_t        mon_e;
    bit          mon_id;
    logic [31:0] mon_rdata;
    logic        mon_err;
    always @(negedge clk) begin
        if (rst_ni) begin
            if ((rsp0_err && !rsp0_valid) || (rsp1_err && !rsp1_valid) ||
                (rsp0_valid && rsp1_valid)) begin
                n_cmp++; n_fail++;
                $display("FAIL rsp_exclusive: cyc=%0d v0=%b v1=%b e0=%b e1=%b, required one owner",
                         cyc, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err);
            end else if (rsp0_valid || rsp1_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: cyc=%0d v0=%b v1=%b, required none",
                             cyc, rsp0_valid, rsp1_valid);
                end else begin
                    mon_e     = exp_q.pop_front();
                    mon_id    = rsp1_valid;
                    mon_rdata = mon_id ? rsp1_rdata : rsp0_rdata;
                    mon_err   = mon_id ? rsp1_err : rsp0_err;
                    if (mon_id !== mon_e.id || cyc != mon_e.cyc || mon_err !== mon_e.err ||
                        mon_rdata !== mon_e.rdata) begin
                        n_fail++;
                        $display("FAIL rsp: got id=%0d cyc=%0d err=%b rdata=%h, required id=%0d cyc=%0d err=%b rdata=%h",
                                 mon_id, cyc, mon_err, mon_rdata, mon_e.id, mon_e.cyc,
                                 mon_e.err, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic expect_rsp(input bit id, input logic [AW-1:0] a, input bit wr,
                              input logic [31:0] wd, input logic [2:0] fn, input int hs);
        exp_t e;
        e.id = id; e.err = 1'b0; e.rdata = 32'h0;
        if (fn == 3'd3 || fn == 3'd6 || fn == 3'd7) begin
            e.err = 1'b1; e.cyc = hs + 2;
        end else begin
            e.cyc = hs + 3;
            if (wr) ref_mem[a] = merge(ref_mem[a], wd, fn);
            else    e.rdata = ext(ref_mem[a], fn);
        end
        exp_q.push_back(e);
    endtask

    task automatic set_req(input bit id, input bit v, input logic [AW-1:0] a, input bit wr,
                           input logic [31:0] wd, input logic [2:0] fn);
        if (id) begin
            req1_valid = v; req1_addr = a; req1_write = wr; req1_wdata = wd; req1_funct = fn;
        end else begin
            req0_valid = v; req0_addr = a; req0_write = wr; req0_wdata = wd; req0_funct = fn;
        end
    endtask

    // Returns in the cycle after the handshake edge; hs is the handshake cycle.
    task automatic issue(input bit id, input logic [AW-1:0] a, input bit wr,
                         input logic [31:0] wd, input logic [2:0] fn, input bit track,
                         output int hs);
        int i = 0;
        hs = -1;
        @(negedge clk);
        set_req(id, 1'b1, a, wr, wd, fn);
        while (hs < 0 && i < 20) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                hs = cyc;
                if (track) expect_rsp(id, a, wr, wd, fn, hs);
            end else begin
                @(negedge clk);
            end
            i++;
        end
        n_cmp++;
        if (hs < 0) begin
            n_fail++;
            $display("FAIL grant_timeout: req%0d got no ready in 20 cycles, required a grant", id);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 30) begin
            @(negedge clk);
            #1;
            i++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 9'd7, 1'b1, 32'h1234_5678, 3'd2);
        set_req(1, 1'b1, 9'd8, 1'b0, 32'h0, 3'd2);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, penable, pwrite, rsp0_valid, rsp1_valid, rsp0_err,
             rsp1_err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%b%b en=%b wr=%b v=%b%b e=%b%b, required all 0",
                     req0_ready, req1_ready, penable, pwrite, rsp0_valid, rsp1_valid,
                     rsp0_err, rsp1_err);
        end
        n_cmp++;
        if (paddr !== '0 || pwdata !== 32'h0 || pfunct !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_bank: addr=%h wdata=%h funct=%0d, required 0", paddr, pwdata,
                     pfunct);
        end
        n_cmp++;
        if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: %h %h, required 0", rsp0_rdata, rsp1_rdata);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_store_load();
        int hs;
        issue(0, 9'd5, 1'b1, 32'hDEAD_BEEF, 3'd2, 1'b1, hs);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (penable !== (k == 2) || paddr !== 9'd5 || pwrite !== 1'b1 ||
                pwdata !== 32'hDEAD_BEEF || pfunct !== 3'd2) begin
                n_fail++;
                $display("FAIL store_bus_hs+%0d: en=%b addr=%h wr=%b wd=%h fn=%0d, required en=%b addr=5 wr=1 wd=deadbeef fn=2",
                         k, penable, paddr, pwrite, pwdata, pfunct, (k == 2));
            end
        end
        issue(0, 9'd5, 1'b0, 32'h0, 3'd2, 1'b1, hs);
        drain();
        n_cmp++;
        if (rsp0_rdata !== 32'hDEAD_BEEF || rsp0_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_word: rdata=%h err=%b, required deadbeef err=0", rsp0_rdata,
                     rsp0_err);
        end
    endtask

    task automatic test_sign_ext();
        int hs;
        issue(0, 9'd9, 1'b1, 32'h0000_0080, 3'd0, 1'b1, hs);
        issue(1, 9'd9, 1'b0, 32'h0, 3'd4, 1'b1, hs);
        drain();
        n_cmp++;
        if (rsp1_rdata !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL lbu: rdata=%h, required 00000080", rsp1_rdata);
        end
        issue(1, 9'd9, 1'b0, 32'h0, 3'd0, 1'b1, hs);
        drain();
        n_cmp++;
        if (rsp1_rdata !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb: rdata=%h, required ffffff80", rsp1_rdata);
        end
        issue(1, 9'd9, 1'b0, 32'h0, 3'd1, 1'b1, hs);
        drain();
    endtask

    task automatic test_illegal();
        int hs;
        issue(0, 9'd3, 1'b0, 32'h0, 3'd7, 1'b1, hs);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (penable !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_penable_hs+%0d: en=%b, required 0", k, penable);
            end
            if (k == 2) begin
                n_cmp++;
                if (!(rsp0_valid === 1'b1 && rsp0_err === 1'b1 && rsp0_rdata === 32'h0)) begin
                    n_fail++;
                    $display("FAIL illegal_rsp: v=%b err=%b rdata=%h, required v=1 err=1 rdata=0",
                             rsp0_valid, rsp0_err, rsp0_rdata);
                end
            end
        end
        issue(1, 9'd4, 1'b0, 32'h0, 3'd3, 1'b1, hs);
        issue(0, 9'd4, 1'b1, 32'h5555_AAAA, 3'd6, 1'b1, hs);
        issue(1, 9'd4, 1'b0, 32'h0, 3'd2, 1'b1, hs);
        drain();
    endtask

    task automatic test_round_robin();
        int  grants = 0;
        int  last_hs = -1;
        bit  want = 1'b0;
        bit  win;
        do_reset();
        set_req(0, 1'b1, 9'd5, 1'b0, 32'h0, 3'd2);
        set_req(1, 1'b1, 9'd9, 1'b0, 32'h0, 3'd0);
        for (int i = 0; i < 40 && grants < 8; i++) begin
            @(negedge clk);
            #1;
            if (req0_ready || req1_ready) begin
                win = req1_ready;
                n_cmp++;
                if ((req0_ready && req1_ready) || win !== want ||
                    (last_hs >= 0 && cyc - last_hs != 3)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: rdy=%b%b gap=%0d, required winner %0d gap 3",
                             grants, req0_ready, req1_ready, cyc - last_hs, want);
                end
                expect_rsp(win, win ? req1_addr : req0_addr, 1'b0, 32'h0,
                           win ? req1_funct : req0_funct, cyc);
                want = ~win;
                last_hs = cyc;
                grants++;
            end
        end
        n_cmp++;
        if (grants != 8) begin
            n_fail++;
            $display("FAIL rr_count: %0d grants, required 8", grants);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_access();
        int hs;
        int rel;
        issue(0, 9'd20, 1'b1, 32'h1234_5678, 3'd2, 1'b0, hs);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (penable !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_en: en=%b, required 1", penable);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (penable !== 1'b0) begin
            n_fail++;
            $display("FAIL async_drop: en=%b, required 0", penable);
        end
        set_req(1, 1'b1, 9'd20, 1'b0, 32'h0, 3'd2);
        #1;
        n_cmp++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_reset: rdy1=%b, required 0", req1_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        rel = cyc;
        issue(1, 9'd20, 1'b0, 32'h0, 3'd2, 1'b1, hs);
        n_cmp++;
        if (hs != rel) begin
            n_fail++;
            $display("FAIL first_grant: cycle %0d, required %0d", hs, rel);
        end
        drain();
    endtask

    task automatic test_xz();
        int hs;
        issue(1, 9'd5, 1'b0, 32'h0, 3'd2, 1'b1, hs);
        issue(0, 9'd9, 1'b0, 32'h0, 3'd5, 1'b1, hs);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ($isunknown(rsp0_rdata) || $isunknown(rsp1_rdata)) begin
                n_fail++;
                $display("FAIL rdata_known: %h %h, required no X/Z", rsp0_rdata, rsp1_rdata);
            end
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_store_load();
        test_sign_ext();
        test_illegal();
        test_round_robin();
        test_reset_mid_access();
        test_xz();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: bench still running at 200us, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/dmem_bank_arbiter.md
DMEM_BANK_ARBITER -- requirements
Module: dmem_bank_arbiter

Interface
REQ-001 SHALL have parameter DMEM_ADDR, default 9, giving the word-address width of the data-memory bank.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have, for each requester n in {0,1}, port reqn_valid_i, input, 1, request pending.
REQ-005 SHALL have reqn_ready_o, output, 1, request accepted this cycle when high with reqn_valid_i.
REQ-006 SHALL have reqn_addr_i, input, DMEM_ADDR, bank word address.
REQ-007 SHALL have reqn_write_i, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have reqn_wdata_i, input, 32, store data.
REQ-009 SHALL have reqn_funct_i, input, 3, access code: 0 = byte, 1 = half, 2 = word, 4 = byte unsigned, 5 = half unsigned.
REQ-010 SHALL have rspn_valid_o, output, 1, one-cycle completion pulse.
REQ-011 SHALL have rspn_rdata_o, output, 32, load result.
REQ-012 SHALL have rspn_err_o, output, 1, illegal access code, valid with rspn_valid_o.
REQ-013 SHALL have bank-side ports paddr_o (DMEM_ADDR), penable_o (1), pwrite_o (1), pwdata_o (32) and pfunct_code_o (3), all outputs.
REQ-014 SHALL have prdata_i, input, 32, bank read data, which is high-Z when penable_o is low.

Function
REQ-015 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> IDLE, one cycle per state outside IDLE.
REQ-016 SHALL assert reqn_ready_o only in IDLE, for at most one requester, and only to the arbitration winner.
REQ-017 SHALL arbitrate round-robin: when both are valid, the requester other than the last granted wins; the pointer resets to favour requester 0.
REQ-018 SHALL let a lone valid requester win regardless of the pointer, and SHALL update the pointer on every grant.
REQ-019 SHALL, on handshake, register addr, write, wdata, funct and the owner id into paddr_o, pwrite_o, pwdata_o, pfunct_code_o and an owner register, then enter SETUP.
REQ-020 SHALL hold penable_o = 0 in SETUP and drive penable_o = 1 for exactly the one ACCESS cycle.
REQ-021 SHALL treat the clock edge that ends ACCESS as the store-commit edge, and SHALL sample prdata_i on that edge for loads.
REQ-022 SHALL hold the bank address/control/data outputs stable from SETUP through ACCESS, and afterwards until the next grant.
REQ-023 SHALL pulse rspn_valid_o for the owner for one cycle in the IDLE cycle that follows ACCESS, with latency handshake edge + 3 cycles.
REQ-024 SHALL make a load's rspn_rdata_o equal the sampled prdata_i.
REQ-025 SHALL drive a store's rspn_rdata_o = 0.
REQ-026 SHALL hold rspn_rdata_o between responses.
REQ-027 SHALL treat funct codes 3, 6 and 7 as illegal: take the SETUP state, skip ACCESS (penable_o stays 0) and return to IDLE.
REQ-028 SHALL, for an illegal code, pulse rspn_valid_o with rspn_err_o = 1 and rdata 0, with latency handshake edge + 2 cycles.
REQ-029 SHALL never sample or forward prdata_i outside ACCESS, so high-Z never reaches rspn_rdata_o.
REQ-030 SHALL allow a new grant in the same IDLE cycle as a response pulse, giving a throughput of one access per 3 cycles.
REQ-031 SHALL keep the non-owner's rsp outputs at valid 0, err 0.

Reset
REQ-032 SHALL, while rst_ni = 0, drive state IDLE, penable_o = 0, pwrite_o = 0, paddr_o = 0, pwdata_o = 0, pfunct_code_o = 0, both ready = 0, both rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, pointer = requester 0.
REQ-033 SHALL, on reset asserted mid-SETUP or mid-ACCESS, drop penable_o immediately and asynchronously, issue no response for the in-flight access, and start the first post-reset grant from IDLE.

Verification
REQ-034 SHALL cover: req0 word store addr 5 data 0xDEADBEEF, then req0 word load addr 5 -> penable high one cycle each, rsp0_rdata = 0xDEADBEEF at handshake + 3, err 0.
REQ-035 SHALL cover: both valid continuously after reset -> grants alternate 0,1,0,1, rsp pulses alternate, each one cycle, no starvation.
REQ-036 SHALL cover: req1 load funct 4 of byte 0x80 -> rsp1_rdata = 0x00000080; funct 0 -> 0xFFFFFF80.
REQ-037 SHALL cover: req0 funct 7 -> penable_o never high, rsp0_valid and rsp0_err high at handshake + 2, rdata 0.
REQ-038 SHALL cover: rst_ni low during ACCESS of a store -> penable_o low immediately, no rsp pulse, and after reset req1 alone is granted first cycle.
REQ-039 SHALL cover: prdata_i driven X/Z outside ACCESS -> rsp rdata never X/Z.
